// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: CDB field widths,
// requester index constants and the broadcast payload layout.
package cdb_arbiter_pkg;

    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;

    localparam int REQ_LS  = 0;
    localparam int REQ_INT = 1;
    localparam int REQ_MUL = 2;
    localparam int REQ_BR  = 3;

    typedef struct packed {
        logic              branch;
        logic              branch_taken;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_payload_t;

endpackage

// File: rtl/cdb_age_pick.sv
// Per-requester age counters and fixed-priority select with age promotion.
// Produces a one-hot (or zero) grant; a flush suppresses the grant and clears all ages.
module cdb_age_pick #(
    parameter int NUM_REQ   = 4,
    parameter int AGE_LIMIT = 8,
    parameter int AGE_W     = 4
) (
    input  logic               clock,
    input  logic               nreset,
    input  logic               flush_valid,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_LIMIT);

    logic [AGE_W-1:0]   age_q [NUM_REQ];
    logic [AGE_W-1:0]   age_d [NUM_REQ];
    logic [NUM_REQ-1:0] promoted;
    logic [NUM_REQ-1:0] cand;

    always_comb begin
        promoted = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            promoted[i] = req_valid[i] && (age_q[i] >= AGE_LIM);
        end
        // Promoted requesters form their own priority tier, lowest index first.
        cand  = (|promoted) ? promoted : req_valid;
        grant = cand & (~cand + NUM_REQ'(1));
        if (flush_valid) begin
            grant = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            age_d[i] = '0;
            if (!flush_valid && req_valid[i] && !grant[i]) begin
                age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one grant per cycle, registered broadcast the next cycle.
// Optional performance counters are built when CDB_ARB_PERF_EN is defined.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int AGE_LIMIT = 8,
    parameter int AGE_W     = 4
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        flush_valid,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_branch,
    input  logic [NUM_REQ-1:0]          req_branch_taken,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        cdb_valid,
    output logic                        cdb_branch,
    output logic                        cdb_branch_taken,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_data,
    output logic [$clog2(NUM_REQ)-1:0]  cdb_src
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]       perf_grant_cnt,
    output logic [15:0]                 perf_conflict_cnt
`endif
);

    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    cdb_payload_t       sel_payload;
    logic [SRC_W-1:0]   sel_src;

    cdb_payload_t       payload_q, payload_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic               cdb_valid_q, cdb_valid_d;

    cdb_age_pick #(
        .NUM_REQ   (NUM_REQ),
        .AGE_LIMIT (AGE_LIMIT),
        .AGE_W     (AGE_W)
    ) u_age_pick (
        .clock       (clock),
        .nreset      (nreset),
        .flush_valid (flush_valid),
        .req_valid   (req_valid),
        .grant       (grant)
    );

    // Grant is combinational, so it must also be held off while reset is asserted.
    assign req_ready = grant & {NUM_REQ{nreset}};

    always_comb begin
        sel_payload = '0;
        sel_src     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_payload.branch       = req_branch[i];
                sel_payload.branch_taken = req_branch_taken[i];
                sel_payload.tag          = req_tag[i*TAG_W +: TAG_W];
                sel_payload.data         = req_data[i*DATA_W +: DATA_W];
                sel_src                  = SRC_W'(i);
            end
        end
    end

    always_comb begin
        cdb_valid_d = |grant;
        payload_d   = (|grant) ? sel_payload : payload_q;
        src_d       = (|grant) ? sel_src : src_q;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            cdb_valid_q <= 1'b0;
            payload_q   <= '0;
            src_q       <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            payload_q   <= payload_d;
            src_q       <= src_d;
        end
    end

    assign cdb_valid        = cdb_valid_q;
    assign cdb_branch       = payload_q.branch;
    assign cdb_branch_taken = payload_q.branch_taken;
    assign cdb_tag          = payload_q.tag;
    assign cdb_data         = payload_q.data;
    assign cdb_src          = src_q;

`ifdef CDB_ARB_PERF_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] grant_cnt_d [NUM_REQ];
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic        multi_valid;

    always_comb begin
        multi_valid = |(req_valid & (req_valid - NUM_REQ'(1)));
        conflict_cnt_d = conflict_cnt_q;
        if (multi_valid && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (req_ready[i] && grant_cnt_q[i] != 16'hFFFF) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
            end
        end
    end

    // Counters survive flushes; only reset clears them.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            conflict_cnt_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            grant_cnt_q    <= grant_cnt_d;
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_grant_cnt[i*16 +: 16] = grant_cnt_q[i];
        end
    end

    assign perf_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NUM_REQ=4, AGE_LIMIT=8, AGE_W=4).
module tb_cdb_arbiter;

    logic         clock;
    logic         nreset;
    logic         flush_valid;
    logic [3:0]   req_valid;
    logic [19:0]  req_tag;
    logic [127:0] req_data;
    logic [3:0]   req_branch;
    logic [3:0]   req_branch_taken;
    logic [3:0]   req_ready;
    logic         cdb_valid;
    logic         cdb_branch;
    logic         cdb_branch_taken;
    logic [4:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic [1:0]   cdb_src;
`ifdef CDB_ARB_PERF_EN
    logic [63:0]  perf_grant_cnt;
    logic [15:0]  perf_conflict_cnt;
`endif

    int checks;
    int errors;

    cdb_arbiter #(
        .NUM_REQ   (4),
        .AGE_LIMIT (8),
        .AGE_W     (4)
    ) dut (
        .clock            (clock),
        .nreset           (nreset),
        .flush_valid      (flush_valid),
        .req_valid        (req_valid),
        .req_tag          (req_tag),
        .req_data         (req_data),
        .req_branch       (req_branch),
        .req_branch_taken (req_branch_taken),
        .req_ready        (req_ready),
        .cdb_valid        (cdb_valid),
        .cdb_branch       (cdb_branch),
        .cdb_branch_taken (cdb_branch_taken),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data),
        .cdb_src          (cdb_src)
`ifdef CDB_ARB_PERF_EN
        ,
        .perf_grant_cnt    (perf_grant_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] tag,
                           input logic [31:0] data, input logic br, input logic tk);
        req_valid[i]          = v;
        req_tag[i*5 +: 5]     = tag;
        req_data[i*32 +: 32]  = data;
        req_branch[i]         = br;
        req_branch_taken[i]   = tk;
    endtask

    task automatic clear_reqs();
        req_valid        = '0;
        req_tag          = '0;
        req_data         = '0;
        req_branch       = '0;
        req_branch_taken = '0;
    endtask

    task automatic test_reset();
        next_cycle();
        next_cycle();
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 5'd0 || cdb_data !== 32'd0 || cdb_src !== 2'd0 ||
            cdb_branch !== 1'b0 || cdb_branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_cdb: got v=%b tag=%h data=%h src=%0d br=%b tk=%b, expected all zero",
                     cdb_valid, cdb_tag, cdb_data, cdb_src, cdb_branch, cdb_branch_taken);
        end
        set_req(0, 1'b1, 5'h01, 32'h1, 1'b0, 1'b0);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        clear_reqs();
        @(negedge clock);
        nreset = 1'b1;
        next_cycle();
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 5'h03, 32'hDEADBEEF, 1'b0, 1'b0);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_ready: got %b expected 0010", req_ready);
        end
        next_cycle();
        clear_reqs();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 5'h03 || cdb_data !== 32'hDEADBEEF || cdb_src !== 2'd1) begin
            errors++;
            $display("FAIL single_cdb: got v=%b tag=%h data=%h src=%0d expected v=1 tag=03 data=deadbeef src=1",
                     cdb_valid, cdb_tag, cdb_data, cdb_src);
        end
        next_cycle();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got cdb_valid=%b expected 0", cdb_valid);
        end
    endtask

    task automatic test_priority();
        set_req(0, 1'b1, 5'h04, 32'hA0A0A0A0, 1'b0, 1'b0);
        set_req(2, 1'b1, 5'h06, 32'hC2C2C2C2, 1'b0, 1'b0);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL prio_ready0: got %b expected 0001", req_ready);
        end
        next_cycle();
        set_req(0, 1'b0, 5'h00, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== 5'h04 || cdb_data !== 32'hA0A0A0A0) begin
            errors++;
            $display("FAIL prio_cdb0: got v=%b src=%0d tag=%h data=%h expected v=1 src=0 tag=04 data=a0a0a0a0",
                     cdb_valid, cdb_src, cdb_tag, cdb_data);
        end
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL prio_ready2: got %b expected 0100", req_ready);
        end
        next_cycle();
        clear_reqs();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd2 || cdb_tag !== 5'h06 || cdb_data !== 32'hC2C2C2C2) begin
            errors++;
            $display("FAIL prio_cdb2: got v=%b src=%0d tag=%h data=%h expected v=1 src=2 tag=06 data=c2c2c2c2",
                     cdb_valid, cdb_src, cdb_tag, cdb_data);
        end
        next_cycle();
    endtask

    task automatic test_aging();
        logic [3:0] exp_ready;
        for (int c = 0; c < 10; c++) begin
            set_req(0, 1'b1, 5'(c), 32'h1000 + 32'(c), 1'b0, 1'b0);
            set_req(3, (c <= 8), 5'h1F, 32'h33333333, 1'b0, 1'b0);
            #1;
            exp_ready = (c == 8) ? 4'b1000 : 4'b0001;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL aging_ready c=%0d: got %b expected %b", c, req_ready, exp_ready);
            end
            next_cycle();
            checks++;
            if (c == 8) begin
                if (cdb_valid !== 1'b1 || cdb_src !== 2'd3 || cdb_tag !== 5'h1F) begin
                    errors++;
                    $display("FAIL aging_cdb c=%0d: got v=%b src=%0d tag=%h expected v=1 src=3 tag=1f",
                             c, cdb_valid, cdb_src, cdb_tag);
                end
            end else begin
                if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== 5'(c)) begin
                    errors++;
                    $display("FAIL aging_cdb c=%0d: got v=%b src=%0d tag=%h expected v=1 src=0 tag=%h",
                             c, cdb_valid, cdb_src, cdb_tag, 5'(c));
                end
            end
        end
        clear_reqs();
        next_cycle();
    endtask

    task automatic test_flush();
        logic [3:0] exp_ready;
        for (int c = 0; c < 5; c++) begin
            set_req(0, 1'b1, 5'(8 + c), 32'h2000 + 32'(c), 1'b0, 1'b0);
            set_req(2, 1'b1, 5'h12, 32'h22222222, 1'b0, 1'b0);
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                errors++;
                $display("FAIL flush_pre_ready c=%0d: got %b expected 0001", c, req_ready);
            end
            next_cycle();
        end
        set_req(0, 1'b0, 5'h00, 32'h0, 1'b0, 1'b0);
        set_req(1, 1'b1, 5'h11, 32'h11111111, 1'b0, 1'b0);
        flush_valid = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL flush_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== 5'd12) begin
            errors++;
            $display("FAIL flush_inflight: got v=%b src=%0d tag=%h expected v=1 src=0 tag=0c",
                     cdb_valid, cdb_src, cdb_tag);
        end
        next_cycle();
        flush_valid = 1'b0;
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cdb: got cdb_valid=%b expected 0", cdb_valid);
        end
        // Unit 2 presents a fresh result right after the flush; it must start from age 0.
        set_req(1, 1'b0, 5'h00, 32'h0, 1'b0, 1'b0);
        set_req(2, 1'b1, 5'h0A, 32'hAAAA5555, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            set_req(0, 1'b1, 5'(16 + k), 32'h3000 + 32'(k), 1'b0, 1'b0);
            #1;
            exp_ready = (k == 8) ? 4'b0100 : 4'b0001;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL flush_age k=%0d: got %b expected %b", k, req_ready, exp_ready);
            end
            next_cycle();
        end
        clear_reqs();
        next_cycle();
    endtask

    task automatic test_branch();
        set_req(3, 1'b1, 5'h07, 32'h00001234, 1'b1, 1'b1);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL branch_ready: got %b expected 1000", req_ready);
        end
        next_cycle();
        clear_reqs();
        set_req(1, 1'b1, 5'h08, 32'h00005678, 1'b0, 1'b0);
        checks++;
        if (cdb_valid !== 1'b1 || cdb_branch !== 1'b1 || cdb_branch_taken !== 1'b1 ||
            cdb_src !== 2'd3 || cdb_tag !== 5'h07) begin
            errors++;
            $display("FAIL branch_cdb: got v=%b br=%b tk=%b src=%0d tag=%h expected v=1 br=1 tk=1 src=3 tag=07",
                     cdb_valid, cdb_branch, cdb_branch_taken, cdb_src, cdb_tag);
        end
        next_cycle();
        clear_reqs();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_branch !== 1'b0 || cdb_branch_taken !== 1'b0 || cdb_src !== 2'd1) begin
            errors++;
            $display("FAIL nonbranch_cdb: got v=%b br=%b tk=%b src=%0d expected v=1 br=0 tk=0 src=1",
                     cdb_valid, cdb_branch, cdb_branch_taken, cdb_src);
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        set_req(1, 1'b1, 5'h09, 32'hCAFEF00D, 1'b0, 1'b0);
        next_cycle();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL areset_pre: got v=%b data=%h expected v=1 data=cafef00d", cdb_valid, cdb_data);
        end
        #2;
        nreset = 1'b0;
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_data !== 32'd0 || cdb_tag !== 5'd0) begin
            errors++;
            $display("FAIL areset_async: got v=%b data=%h tag=%h expected all zero", cdb_valid, cdb_data, cdb_tag);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL areset_ready: got %b expected 0000", req_ready);
        end
        clear_reqs();
        next_cycle();
        @(negedge clock);
        nreset = 1'b1;
        next_cycle();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_stale: got cdb_valid=%b expected 0", cdb_valid);
        end
        next_cycle();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_stale2: got cdb_valid=%b expected 0", cdb_valid);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        nreset      = 1'b0;
        flush_valid = 1'b0;
        clear_reqs();
        test_reset();
        test_single();
        test_priority();
        test_aging();
        test_flush();
        test_branch();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
